// File: rtl/bit_stream_feeder.sv
// Bit-serial feeder for the BDU distance unit: takes one query/reference
// point pair per handshake and streams it MSB-first, x/y/z interleaved per
// bit step, one beat per cycle. A one-entry prefetch buffer allows
// back-to-back points with no bubble; BDU early termination ends the
// current point at once.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   pt_valid / pt_ready         point handshake (pt_ready = buffer empty)
//   q_x,q_y,q_z / r_x,r_y,r_z   query / reference coordinates, B bits each
//   pt_id                       tag travelling with the point
//   terminate                   BDU early termination for the point on the outputs
//   valid,q_bit,r_bit,code,b    beat to the BDU (code 01/10/11 = x/y/z)
//   out_last, out_id            final-beat flag and tag of the streamed point
//   done_count, abort_count     saturating point counters
module bit_stream_feeder #(
  parameter int unsigned B    = 32,
  parameter int unsigned ID_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [B-1:0]         q_x,
  input  logic [B-1:0]         q_y,
  input  logic [B-1:0]         q_z,
  input  logic [B-1:0]         r_x,
  input  logic [B-1:0]         r_y,
  input  logic [B-1:0]         r_z,
  input  logic [ID_W-1:0]      pt_id,
  input  logic                 terminate,
  output logic                 valid,
  output logic                 q_bit,
  output logic                 r_bit,
  output logic [1:0]           code,
  output logic [$clog2(B)-1:0] b,
  output logic                 out_last,
  output logic [ID_W-1:0]      out_id,
  output logic [15:0]          done_count,
  output logic [15:0]          abort_count
);

  localparam int unsigned KW = $clog2(B);
  localparam int unsigned CW = 16;

  typedef enum logic {IDLE, STREAM} state_t;

  typedef struct packed {
    logic [B-1:0]    q_x;
    logic [B-1:0]    q_y;
    logic [B-1:0]    q_z;
    logic [B-1:0]    r_x;
    logic [B-1:0]    r_y;
    logic [B-1:0]    r_z;
    logic [ID_W-1:0] id;
  } point_t;

  state_t        state;
  point_t        act;
  point_t        buf_pt;
  logic          buf_full;
  logic [KW-1:0] k;        // bit step of the beat on the outputs
  logic [1:0]    ax;       // axis of the beat on the outputs (0..2)

  point_t        in_pt;
  logic          accept_c;
  logic          last_c;
  logic          end_c;
  logic          cont_c;

  point_t        nxt_pt;
  logic          nxt_stream;
  logic [KW-1:0] nxt_k;
  logic [1:0]    nxt_ax;
  logic          nxt_last;
  logic          load_buf_c;
  logic          take_buf_c;
  logic          buf_full_n;
  logic [KW-1:0] idx_c;
  logic [B-1:0]  q_word_c;
  logic [B-1:0]  r_word_c;

  assign in_pt    = {q_x, q_y, q_z, r_x, r_y, r_z, pt_id};
  assign accept_c = pt_valid && pt_ready;
  assign last_c   = (k == KW'(B - 1)) && (ax == 2'd2);
  // terminate only matters while a beat is actually on the outputs
  assign end_c    = (state == STREAM) && (last_c || terminate);
  assign cont_c   = (state == STREAM) && !end_c;

  // Choose the point and beat index to present after this edge
  always_comb begin
    nxt_pt     = act;
    nxt_stream = 1'b0;
    nxt_k      = '0;
    nxt_ax     = '0;
    load_buf_c = 1'b0;
    take_buf_c = 1'b0;
    if (cont_c) begin
      nxt_stream = 1'b1;
      load_buf_c = accept_c;
      if (ax == 2'd2) begin
        nxt_ax = 2'd0;
        nxt_k  = k + KW'(1);
      end else begin
        nxt_ax = ax + 2'd1;
        nxt_k  = k;
      end
    end else if (buf_full) begin
      // buffered point follows immediately, no bubble
      nxt_stream = 1'b1;
      nxt_pt     = buf_pt;
      take_buf_c = 1'b1;
    end else if (accept_c) begin
      nxt_stream = 1'b1;
      nxt_pt     = in_pt;
    end
  end

  assign buf_full_n = load_buf_c || (buf_full && !take_buf_c);
  assign nxt_last   = (nxt_k == KW'(B - 1)) && (nxt_ax == 2'd2);
  // B is a power of two, so B-1-k is the bitwise complement of k
  assign idx_c      = ~nxt_k;

  // Axis word of the next beat
  always_comb begin
    q_word_c = nxt_pt.q_z;
    r_word_c = nxt_pt.r_z;
    case (nxt_ax)
      2'd0: begin
        q_word_c = nxt_pt.q_x;
        r_word_c = nxt_pt.r_x;
      end
      2'd1: begin
        q_word_c = nxt_pt.q_y;
        r_word_c = nxt_pt.r_y;
      end
      default: begin
        q_word_c = nxt_pt.q_z;
        r_word_c = nxt_pt.r_z;
      end
    endcase
  end

  // State, point storage and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      act         <= '0;
      buf_pt      <= '0;
      buf_full    <= 1'b0;
      k           <= '0;
      ax          <= '0;
      pt_ready    <= 1'b0;
      valid       <= 1'b0;
      q_bit       <= 1'b0;
      r_bit       <= 1'b0;
      code        <= 2'b00;
      b           <= '0;
      out_last    <= 1'b0;
      out_id      <= '0;
      done_count  <= '0;
      abort_count <= '0;
    end else begin
      state    <= nxt_stream ? STREAM : IDLE;
      act      <= nxt_pt;
      k        <= nxt_k;
      ax       <= nxt_ax;
      buf_full <= buf_full_n;
      pt_ready <= !buf_full_n;
      if (load_buf_c) begin
        buf_pt <= in_pt;
      end

      valid    <= nxt_stream;
      q_bit    <= nxt_stream && q_word_c[idx_c];
      r_bit    <= nxt_stream && r_word_c[idx_c];
      code     <= nxt_stream ? (nxt_ax + 2'd1) : 2'b00;
      b        <= nxt_stream ? KW'(nxt_k + KW'(1)) : KW'(0);
      out_last <= nxt_stream && nxt_last;
      out_id   <= nxt_pt.id;

      // a terminate on the last beat still counts as a completion
      if (valid && out_last && (done_count != CW'(16'hFFFF))) begin
        done_count <= done_count + CW'(1);
      end
      if (valid && terminate && !out_last && (abort_count != CW'(16'hFFFF))) begin
        abort_count <= abort_count + CW'(1);
      end
    end
  end

endmodule
